lcd_arbiter: RTL

LCD_ARBITER -- requirements
Module: lcd_arbiter

---
 rtl/lcd_arb_pkg.sv | 23 ++
 rtl/lcd_arb_fifo.sv | 79 +++++++
 rtl/lcd_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lcd_arb_pkg.sv
// Shared definitions for the two-port LCD command arbiter: FSM encodings,
// command layout and instruction codes.
package lcd_arb_pkg;

    localparam int CMD_W = 10;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAITBUSY = 2'd2;
    localparam logic [1:0] S_WAITDONE = 2'd3;

    localparam logic [1:0] INST_CHAR_WRITE = 2'd0;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] data;
    } lcd_cmd_t;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic [1:0] inst, input logic [7:0] data);
        return {inst, data};
    endfunction

endpackage

// File: rtl/lcd_arb_fifo.sv
// Per-port command FIFO; full/empty are registered so the port busy flag
// comes straight from a flop.
module lcd_arb_fifo
    import lcd_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CMD_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [CMD_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accepted push/pop and next occupancy; a pop never frees room for a same-cycle push.
    always_comb begin
        push_ok_s    = push & ~full_r;
        pop_ok_s     = pop & ~empty_r;
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_CNT);
            empty_r <= (count_next_s == CNT_ZERO);
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/lcd_arbiter.sv
// Two-port round-robin arbiter feeding a single LCD controller, with a
// handshake that tolerates a controller which never raises busy.
module lcd_arbiter
    import lcd_arb_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       A_EXEC,
    input  logic [1:0] A_INST,
    input  logic [7:0] A_CHAR,
    output logic       A_BUSY,
    input  logic       B_EXEC,
    input  logic [1:0] B_INST,
    input  logic [7:0] B_CHAR,
    output logic       B_BUSY,
    input  logic       LCD_BUSY,
    output logic       LCD_EXEC,
    output logic [1:0] LCD_INST,
    output logic [7:0] LCD_CHAR,
    output logic       GRANT,
    output logic [1:0] DROP
);

    localparam int WCW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(BUSY_WAIT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);
    localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);

    logic             a_full_s, a_empty_s, a_pop_s;
    logic             b_full_s, b_empty_s, b_pop_s;
    logic [CMD_W-1:0] a_head_s, b_head_s;
    logic             start_s;
    logic             sel_b_s;
    lcd_cmd_t         sel_cmd_s;
    logic [1:0]       state_r, state_next_s;
    logic [WCW-1:0]   wait_cnt_r;
    logic             lcd_exec_r;
    lcd_cmd_t         lcd_cmd_r;
    logic             grant_r;
    logic [1:0]       drop_r;

    lcd_arb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .CLK   (CLK),
        .RST   (RST),
        .push  (A_EXEC),
        .pop   (a_pop_s),
        .din   (pack_cmd(A_INST, A_CHAR)),
        .full  (a_full_s),
        .empty (a_empty_s),
        .head  (a_head_s)
    );

    lcd_arb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .CLK   (CLK),
        .RST   (RST),
        .push  (B_EXEC),
        .pop   (b_pop_s),
        .din   (pack_cmd(B_INST, B_CHAR)),
        .full  (b_full_s),
        .empty (b_empty_s),
        .head  (b_head_s)
    );

    // Port selection: a lone non-empty port wins, a tie goes to the port not last granted.
    always_comb begin
        start_s = 1'b0;
        sel_b_s = 1'b0;
        if ((state_r == S_IDLE) && !LCD_BUSY && (!a_empty_s || !b_empty_s)) begin
            start_s = 1'b1;
            if (!a_empty_s && !b_empty_s) begin
                sel_b_s = ~grant_r;
            end else begin
                sel_b_s = a_empty_s;
            end
        end else begin
            start_s = 1'b0;
            sel_b_s = 1'b0;
        end
        a_pop_s   = start_s & ~sel_b_s;
        b_pop_s   = start_s & sel_b_s;
        sel_cmd_s = sel_b_s ? b_head_s : a_head_s;
    end

    // Issue handshake state transitions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    state_next_s = S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: state_next_s = S_WAITBUSY;
            S_WAITBUSY: begin
                if (LCD_BUSY) begin
                    state_next_s = S_WAITDONE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAITBUSY;
                end
            end
            S_WAITDONE: begin
                if (!LCD_BUSY) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAITDONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM, issue registers and drop pulses; the exec strobe is registered so it lines up with S_ISSUE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= WAIT_ZERO;
            lcd_exec_r <= 1'b0;
            lcd_cmd_r  <= '{inst: 2'd0, data: 8'd0};
            grant_r    <= 1'b1;
            drop_r     <= 2'b00;
        end else begin
            state_r    <= state_next_s;
            lcd_exec_r <= start_s;
            if (start_s) begin
                lcd_cmd_r <= sel_cmd_s;
                grant_r   <= sel_b_s;
            end
            wait_cnt_r <= (state_r == S_WAITBUSY) ? (wait_cnt_r + WAIT_ONE) : WAIT_ZERO;
            drop_r     <= {B_EXEC & b_full_s, A_EXEC & a_full_s};
        end
    end

    assign A_BUSY   = a_full_s;
    assign B_BUSY   = b_full_s;
    assign LCD_EXEC = lcd_exec_r;
    assign LCD_INST = lcd_cmd_r.inst;
    assign LCD_CHAR = lcd_cmd_r.data;
    assign GRANT    = grant_r;
    assign DROP     = drop_r;

endmodule
